// File: rtl/aes_enc_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_iter_core
// Purpose  : Iterative AES-128/AES-256 encryptor. One round datapath is reused
//            for every round; round keys come from an external store by index.
//            Optional abort input enabled by defining AES_ENC_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_enc_iter_core #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 128,
    parameter int NR_128     = 10,
    parameter int NR_256     = 14
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef AES_ENC_ABORT_EN
    input  logic                           abort,
`endif
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           key_len,
    output logic [$clog2(NR_256+1)-1:0]    rk_idx,
    input  logic [KEY_WIDTH-1:0]           rk_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data
);

    localparam int RIDX_W = $clog2(NR_256 + 1);
    localparam logic [RIDX_W-1:0] C_NR_128 = RIDX_W'(NR_128);
    localparam logic [RIDX_W-1:0] C_NR_256 = RIDX_W'(NR_256);
    localparam logic [RIDX_W-1:0] C_ONE    = RIDX_W'(1);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return C_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the block sits at bits [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_t                  fsm_q,   fsm_d;
    logic [RIDX_W-1:0]     round_q, round_d;
    logic [RIDX_W-1:0]     nr_q,    nr_d;
    logic [DATA_WIDTH-1:0] state_q, state_d;

    logic                  w_abort;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_sb;
    logic [DATA_WIDTH-1:0] w_mc;
    logic [DATA_WIDTH-1:0] w_round_out;

`ifdef AES_ENC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last      = (round_q == nr_q);
    assign w_sb        = sub_bytes(shift_rows(state_q));
    assign w_mc        = mix_columns(w_sb);
    assign w_round_out = (w_last ? w_sb : w_mc) ^ rk_data;

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign out_data  = state_q;
    assign rk_idx    = (fsm_q == S_RUN) ? round_q : '0;

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        nr_d    = nr_q;
        state_d = state_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ rk_data;
                    nr_d    = key_len ? C_NR_256 : C_NR_128;
                    round_d = C_ONE;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    fsm_d   = S_IDLE;
                    round_d = '0;
                    state_d = '0;
                end else if (w_last) begin
                    state_d = w_round_out;
                    round_d = '0;
                    fsm_d   = S_DONE;
                end else begin
                    state_d = w_round_out;
                    round_d = round_q + C_ONE;
                end
            end
            S_DONE: begin
                // Abort wins over the output handshake and clears the result.
                if (w_abort) begin
                    fsm_d   = S_IDLE;
                    round_d = '0;
                    state_d = '0;
                end else if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d   = S_IDLE;
                round_d = '0;
                state_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            round_q <= '0;
            nr_q    <= C_NR_128;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            state_q <= state_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_enc_iter_core
// Purpose  : Self-checking bench for aes_enc_iter_core against FIPS-197 vectors
//            and a byte-level AES reference model (abort tests with AES_ENC_ABORT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_enc_iter_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         key_len;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef AES_ENC_ABORT_EN
    logic         abort;
`endif

    aes_enc_iter_core u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_ENC_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_len   (key_len),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   sb [256];
    logic [127:0] rk_tab [16];
    int           cur_nr;
    int           n_cmp = 0;
    int           n_fail = 0;
    int           rk_log [$];
    bit           saw_ready;
    int           acc_cyc;

    assign rk_data = rk_tab[rk_idx];

    localparam logic [127:0] C_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C_KEY1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C_KEY3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C_CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_CT3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        d = d << n;
        return d[15:8];
    endfunction

    // S-box from the definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input bit klen);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nk;
        nk     = klen ? 8 : 4;
        cur_nr = klen ? 14 : 10;
        rcon   = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(cur_nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= cur_nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k;
        logic [127:0] res;
        k = rk_tab[0];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 1; rnd <= cur_nr; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < cur_nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            k = rk_tab[rnd];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic accept_block(input logic [127:0] pt, input bit klen);
        int waited = 0;
        while (!in_ready && waited < 40) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1 within 40 cycles", in_ready);
        end
        rk_log.delete();
        rk_log.push_back(int'(rk_idx));
        saw_ready = 1'b0;
        acc_cyc   = cyc;
        in_valid  = 1'b1;
        in_data   = pt;
        key_len   = klen;
        @(posedge clk); @(negedge clk);
        in_valid  = 1'b0;
        in_data   = rand128();
        key_len   = 1'($urandom);
    endtask

    // Runs from the cycle after accept until out_valid; edges counts the accept edge.
    task automatic step_to_done(output int edges);
        edges = 1;
        while (!out_valid && edges <= 20) begin
            rk_log.push_back(int'(rk_idx));
            if (in_ready) saw_ready = 1'b1;
            in_valid  = 1'($urandom);
            in_data   = rand128();
            key_len   = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); @(negedge clk);
            edges++;
        end
        if (!out_valid) edges = -1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic int rk_seq_bad();
        if (rk_log.size() != cur_nr + 1) return 99;
        for (int i = 0; i < rk_log.size(); i++)
            if (rk_log[i] != i) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; key_len = 1'b0; out_ready = 1'b0;
`ifdef AES_ENC_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, rk_idx, out_data} !== {1'b1, 1'b0, 4'd0, 128'h0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b idx=%0d data=%h required 1 0 0 0",
                     in_ready, out_valid, rk_idx, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips(input bit klen);
        int e, bad;
        logic [127:0] exp_ct;
        exp_ct = klen ? C_CT3 : C_CT1;
        expand_key(klen ? C_KEY3 : C_KEY1, klen);
        accept_block(C_PT, klen);
        step_to_done(e);
        bad = rk_seq_bad();
        n_cmp++;
        if (e !== cur_nr + 1) begin
            n_fail++; $display("FAIL fips%0d_latency: edges=%0d required %0d", klen, e, cur_nr + 1);
        end
        n_cmp++;
        if (bad !== -1) begin
            n_fail++; $display("FAIL fips%0d_rk_seq: first bad position %0d required none", klen, bad);
        end
        n_cmp++;
        if (saw_ready !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fips%0d_busy: in_ready seen=%b now=%b required 0", klen, saw_ready, in_ready);
        end
        n_cmp++;
        if (out_data !== exp_ct) begin
            n_fail++; $display("FAIL fips%0d_ct: got %h required %h", klen, out_data, exp_ct);
        end
        handshake();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL fips%0d_release: rdy=%b vld=%b required 1 0", klen, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int e;
        bit klen;
        logic [127:0] pt, exp_ct;
        klen = 1'($urandom);
        expand_key({rand128(), rand128()}, klen);
        pt = rand128();
        exp_ct = ref_encrypt(pt);
        accept_block(pt, klen);
        step_to_done(e);
        n_cmp++;
        if (out_data !== exp_ct) begin
            n_fail++; $display("FAIL bp_ct: got %h required %h", out_data, exp_ct);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp_ct}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b data=%h required 1 0 %h",
                         i, out_valid, in_ready, out_data, exp_ct);
            end
        end
        in_valid = 1'b0;
        handshake();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL bp_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int e, a1;
        logic [127:0] pt, exp1, exp2;
        expand_key({rand128(), rand128()}, 1'b0);
        pt = rand128(); exp1 = ref_encrypt(pt);
        accept_block(pt, 1'b0);
        a1 = acc_cyc;
        step_to_done(e);
        n_cmp++;
        if (out_data !== exp1) begin
            n_fail++; $display("FAIL b2b_ct1: got %h required %h", out_data, exp1);
        end
        handshake();
        expand_key({rand128(), rand128()}, 1'b1);
        pt = rand128(); exp2 = ref_encrypt(pt);
        accept_block(pt, 1'b1);
        n_cmp++;
        if (acc_cyc - a1 !== 12) begin
            n_fail++; $display("FAIL b2b_spacing: accept gap %0d cycles required 12", acc_cyc - a1);
        end
        step_to_done(e);
        n_cmp++;
        if (e !== 15 || out_data !== exp2) begin
            n_fail++; $display("FAIL b2b_ct2: edges=%0d got %h required 15 %h", e, out_data, exp2);
        end
        handshake();
    endtask

    task automatic test_random();
        int e;
        bit klen;
        logic [127:0] pt, exp_ct;
        for (int n = 0; n < 6; n++) begin
            klen = 1'($urandom);
            expand_key({rand128(), rand128()}, klen);
            pt = rand128(); exp_ct = ref_encrypt(pt);
            accept_block(pt, klen);
            step_to_done(e);
            n_cmp++;
            if (e !== cur_nr + 1 || out_data !== exp_ct || rk_seq_bad() !== -1) begin
                n_fail++;
                $display("FAIL rand[%0d]: klen=%0d edges=%0d got %h required %0d %h", n, klen, e,
                         out_data, cur_nr + 1, exp_ct);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); @(negedge clk);
            end
            handshake();
        end
    endtask

    task automatic test_mid_reset();
        int e;
        expand_key(C_KEY1, 1'b0);
        accept_block(C_PT, 1'b0);
        repeat (4) begin
            @(posedge clk); @(negedge clk);
        end
        n_cmp++;
        if (rk_idx !== 4'd5) begin
            n_fail++; $display("FAIL mid_rst_round: rk_idx=%0d required 5", rk_idx);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, rk_idx, out_data} !== {1'b0, 1'b1, 4'd0, 128'h0}) begin
            n_fail++;
            $display("FAIL mid_rst_state: vld=%b rdy=%b idx=%0d data=%h required 0 1 0 0",
                     out_valid, in_ready, rk_idx, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        accept_block(C_PT, 1'b0);
        step_to_done(e);
        n_cmp++;
        if (out_data !== C_CT1) begin
            n_fail++; $display("FAIL mid_rst_after: got %h required %h", out_data, C_CT1);
        end
        handshake();
    endtask

    task automatic test_reset_in_done();
        int e;
        expand_key({rand128(), rand128()}, 1'b1);
        accept_block(rand128(), 1'b1);
        step_to_done(e);
        @(posedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_data} !== {1'b0, 128'h0}) begin
            n_fail++; $display("FAIL done_rst: vld=%b data=%h required 0 0", out_valid, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef AES_ENC_ABORT_EN
    task automatic test_abort();
        int e;
        bit seen_valid;
        expand_key(C_KEY1, 1'b0);
        accept_block(C_PT, 1'b0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
        end
        n_cmp++;
        if (rk_idx !== 4'd3) begin
            n_fail++; $display("FAIL abort_round: rk_idx=%0d required 3", rk_idx);
        end
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, rk_idx, out_data} !== {1'b1, 1'b0, 4'd0, 128'h0}) begin
            n_fail++;
            $display("FAIL abort_run: rdy=%b vld=%b idx=%0d data=%h required 1 0 0 0",
                     in_ready, out_valid, rk_idx, out_data);
        end
        seen_valid = 1'b0;
        repeat (15) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        n_cmp++;
        if (seen_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_valid: out_valid seen=%b required 0", seen_valid);
        end
        abort = 1'b1;
        accept_block(C_PT, 1'b0);
        abort = 1'b0;
        step_to_done(e);
        n_cmp++;
        if (e !== 11 || out_data !== C_CT1) begin
            n_fail++; $display("FAIL abort_idle_ignored: edges=%0d got %h required 11 %h", e, out_data, C_CT1);
        end
        abort = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 128'h0}) begin
            n_fail++; $display("FAIL abort_done_prio: rdy=%b vld=%b data=%h required 1 0 0",
                               in_ready, out_valid, out_data);
        end
    endtask
`endif

    initial begin
        for (int r = 0; r < 16; r++) rk_tab[r] = 128'h0;
        build_sbox();
        test_reset();
        test_fips(1'b0);
        test_fips(1'b1);
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_reset_in_done();
`ifdef AES_ENC_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_enc_iter_core.md
Name: aes_enc_iter_core

Overview:
- Iterative AES encrypt engine that reuses one round datapath (ShiftRows, SubBytes/MixColumns, AddRoundKey) for all rounds of one 128-bit block.
- Supports AES-128 (10 rounds) and AES-256 (14 rounds), selected per block.
- Valid/ready handshakes on the input and output sides.
- Round keys come from an external expanded-key store, indexed by this block.

Parameters:
- DATA_WIDTH, 128: block width; only 128 is legal.
- KEY_WIDTH, 128: round-key width; only 128 is legal.
- NR_128, 10: round count when key_len=0.
- NR_256, 14: round count when key_len=1; sets the rk_idx width as clog2(NR_256+1).

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- in_valid, in, 1: in_data and key_len are valid.
- in_ready, out, 1: core can accept a block.
- in_data, in, DATA_WIDTH: plaintext block.
- key_len, in, 1: 0 = AES-128, 1 = AES-256; sampled at accept.
- rk_idx, out, clog2(NR_256+1): index of the round key required this cycle.
- rk_data, in, KEY_WIDTH: round key for rk_idx; must be valid in the same cycle (combinational lookup).
- out_valid, out, 1: ciphertext is valid.
- out_ready, in, 1: downstream accepts the ciphertext.
- out_data, out, DATA_WIDTH: ciphertext block.

Behaviour:
- Reset values: fsm=IDLE, round=0, state register=0, out_valid=0, out_data=0, rk_idx=0, in_ready=1 (decoded from IDLE).
- FSM states: IDLE, RUN, DONE.
- in_ready=(fsm==IDLE); out_valid=(fsm==DONE); out_data=state register.
- IDLE, rk_idx=0:
  - On in_valid&&in_ready: state<=in_data^rk_data, nr<=key_len?NR_256:NR_128, round<=1, go to RUN.
- RUN, rk_idx=round:
  - If round<nr: state<=MixColumns(SubBytes(ShiftRows(state)))^rk_data, round<=round+1.
  - If round==nr: state<=SubBytes(ShiftRows(state))^rk_data (final round, no MixColumns), round<=0, go to DONE.
- DONE, rk_idx=0:
  - Hold out_data stable while !out_ready.
  - On out_ready: go to IDLE.
  - The next block can be accepted in the cycle after the output handshake; there is no same-cycle turnaround.
- Latency: out_valid rises nr+1 rising edges after the accept edge, counting the accept edge (AES-128: 11 edges, AES-256: 15 edges).
- Throughput: one block per nr+2 cycles when out_ready is held high.
- Byte order: in_data[127:120] is byte 0 (FIPS-197 column-major state).
- SubBytes and MixColumns are combinational functions inside the block; there is no ROM latency.
- Boundary conditions:
  - in_valid while RUN or DONE: ignored, no state change.
  - key_len or rk_data changes outside its use cycle: no effect.
  - rst asserted mid-operation: immediately back to reset values; the in-flight block is discarded and out_valid drops asynchronously.
  - out_ready high while not DONE: ignored.
  - round never exceeds nr; rk_idx never exceeds NR_256.

Optional Feature:
- Macro AES_ENC_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort sampled high in RUN or DONE: next edge goes to IDLE, round<=0, state<=0, out_valid=0.
  - abort is ignored in IDLE.
  - abort has priority over round advance and over the out_ready handshake in the same cycle.
- Undefined: no abort port; a block always completes and is held until out_ready.

Test Plan:
- AES-128, FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench supplies expanded keys by rk_idx), pt 00112233445566778899aabbccddeeff, out_ready=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid 11 edges after accept; in_ready low throughout.
- AES-256, FIPS-197 C.3: key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089 after 15 edges; rk_idx sequence 0,1,...,14.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data stable and in_ready=0; then out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle.
- Back-to-back: AES-128 block, then AES-256 block with key_len toggled while busy -> both ciphertexts correct; second accept no earlier than the cycle after the first output handshake.
- Mid-block reset: rst pulse at round 5 -> out_valid=0, rk_idx=0, in_ready=1; the following C.1 block still encrypts correctly.
- With AES_ENC_ABORT_EN: abort at round 3 -> IDLE next edge, no out_valid; the next C.1 block gives 69c4e0d86a7b0430d8cdb78070b4c55a.
